banco_reg_sb: RTL and testbench

- Parametrised next-generation register file for the ULA datapath.
- Two write ports (ALU result and memory/load return) and two read ports.
- Optional write-to-read bypass.
- Per-register busy scoreboard, so the control unit can detect read-after-write hazards on in-flight results.
- Sits between the instruction decode stage and the ULA operand muxes.

---
 rtl/banco_reg_sb_if.sv | 35 +++
 rtl/banco_reg_sb.sv | 92 +++++++++
 tb/tb_banco_reg_sb.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/banco_reg_sb_if.sv
// Bus bundle for banco_reg_sb: two write ports, two read ports and the
// busy-scoreboard control/status signals. The decode stage holds the master
// side and the register file holds the slave side.
interface banco_reg_sb_if #(
  parameter int DataWidth = 8,
  parameter int NumRegs   = 8,
  parameter int AddrWidth = $clog2(NumRegs)
);
  logic                 we3;
  logic [AddrWidth-1:0] wa3;
  logic [DataWidth-1:0] wd3;
  logic                 we4;
  logic [AddrWidth-1:0] wa4;
  logic [DataWidth-1:0] wd4;
  logic [AddrWidth-1:0] ra1;
  logic [AddrWidth-1:0] ra2;
  logic [DataWidth-1:0] rd1;
  logic [DataWidth-1:0] rd2;
  logic                 rsv_en;
  logic [AddrWidth-1:0] rsv_a;
  logic                 busy1;
  logic                 busy2;
  logic [NumRegs-1:0]   busy_vec;
  logic                 clr;

  modport master (
    output we3, wa3, wd3, we4, wa4, wd4, ra1, ra2, rsv_en, rsv_a, clr,
    input  rd1, rd2, busy1, busy2, busy_vec
  );

  modport slave (
    input  we3, wa3, wd3, we4, wa4, wd4, ra1, ra2, rsv_en, rsv_a, clr,
    output rd1, rd2, busy1, busy2, busy_vec
  );
endinterface

// File: rtl/banco_reg_sb.sv
// Two-write / two-read register file with optional write-to-read forwarding
// and a per-register busy scoreboard for read-after-write hazard detection.
// Register 0 is hardwired to zero and can never be marked busy.
module banco_reg_sb #(
  parameter int DataWidth = 8,
  parameter int NumRegs   = 8,
  parameter int AddrWidth = $clog2(NumRegs),
  parameter int Bypass    = 1
) (
  input logic            clk,
  input logic            reset,
  banco_reg_sb_if.slave  bus
);

  localparam logic LBypass = (Bypass != 0);

  logic [DataWidth-1:0] r_regs [NumRegs];
  logic [NumRegs-1:0]   r_busy;
  logic [NumRegs-1:0]   w_busy_nxt;

  logic w_hit3_1, w_hit4_1, w_hit3_2, w_hit4_2;
  logic w_b4_drop;

  // A write forwards to a read port only when bypass is built in, the port is
  // enabled and the addresses match on a nonzero register.
  function automatic logic f_hit(input logic en,
                                 input logic [AddrWidth-1:0] wa,
                                 input logic [AddrWidth-1:0] ra);
    return LBypass && en && (wa == ra) && (ra != '0);
  endfunction

  // Port B loses a same-address collision with port A.
  assign w_b4_drop = bus.we3 && (bus.wa3 == bus.wa4);

  // Register storage: port B first, port A may overwrite; address 0 is never written.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NumRegs; i++) r_regs[i] <= '0;
    end else begin
      if (bus.we4 && (bus.wa4 != '0) && !w_b4_drop) r_regs[bus.wa4] <= bus.wd4;
      if (bus.we3 && (bus.wa3 != '0))               r_regs[bus.wa3] <= bus.wd3;
    end
  end

  // Next busy state: write clears, a younger reservation overrides the write,
  // and a flush overrides everything; bit 0 is forced clear.
  always_comb begin
    w_busy_nxt = r_busy;
    for (int i = 1; i < NumRegs; i++) begin
      if ((bus.we3 && (bus.wa3 == AddrWidth'(i))) ||
          (bus.we4 && (bus.wa4 == AddrWidth'(i))))
        w_busy_nxt[i] = 1'b0;
      if (bus.rsv_en && (bus.rsv_a == AddrWidth'(i)))
        w_busy_nxt[i] = 1'b1;
    end
    if (bus.clr) w_busy_nxt = '0;
    w_busy_nxt[0] = 1'b0;
  end

  // Busy scoreboard register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_busy <= '0;
    else        r_busy <= w_busy_nxt;
  end

  assign w_hit3_1 = f_hit(bus.we3, bus.wa3, bus.ra1);
  assign w_hit4_1 = f_hit(bus.we4, bus.wa4, bus.ra1);
  assign w_hit3_2 = f_hit(bus.we3, bus.wa3, bus.ra2);
  assign w_hit4_2 = f_hit(bus.we4, bus.wa4, bus.ra2);

  // Read port 1: forced zero under reset or for r0, then forwarded data, then storage.
  always_comb begin
    if (!reset || (bus.ra1 == '0)) bus.rd1 = '0;
    else if (w_hit3_1)             bus.rd1 = bus.wd3;
    else if (w_hit4_1)             bus.rd1 = bus.wd4;
    else                           bus.rd1 = r_regs[bus.ra1];
  end

  // Read port 2: same selection as port 1.
  always_comb begin
    if (!reset || (bus.ra2 == '0)) bus.rd2 = '0;
    else if (w_hit3_2)             bus.rd2 = bus.wd3;
    else if (w_hit4_2)             bus.rd2 = bus.wd4;
    else                           bus.rd2 = r_regs[bus.ra2];
  end

  // A forwarded value is available now, so the operand is not reported busy.
  assign bus.busy1    = r_busy[bus.ra1] & ~(w_hit3_1 | w_hit4_1);
  assign bus.busy2    = r_busy[bus.ra2] & ~(w_hit3_2 | w_hit4_2);
  assign bus.busy_vec = r_busy;

endmodule

// File: tb/tb_banco_reg_sb.sv
// Bench for banco_reg_sb: three instances (8x8 with bypass, 8x8 without
// bypass, 16x32 with bypass) share one stimulus stream. A behavioural model
// of register contents and busy bits predicts every output each cycle, and
// directed literal expectations pin the model to the intended behaviour.
module tb_banco_reg_sb;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        we3, we4, rsv_en, clr;
  logic [4:0]  wa3, wa4, ra1, ra2, rsv_a;
  logic [15:0] wd3, wd4;
  bit          chk_en = 1'b0;

  int checks = 0;
  int errors = 0;

  banco_reg_sb_if #(.DataWidth(8),  .NumRegs(8))  ifA ();
  banco_reg_sb_if #(.DataWidth(8),  .NumRegs(8))  ifB ();
  banco_reg_sb_if #(.DataWidth(16), .NumRegs(32)) ifC ();

  assign ifA.we3 = we3;  assign ifA.wa3 = wa3[2:0]; assign ifA.wd3 = wd3[7:0];
  assign ifA.we4 = we4;  assign ifA.wa4 = wa4[2:0]; assign ifA.wd4 = wd4[7:0];
  assign ifA.ra1 = ra1[2:0]; assign ifA.ra2 = ra2[2:0];
  assign ifA.rsv_en = rsv_en; assign ifA.rsv_a = rsv_a[2:0]; assign ifA.clr = clr;

  assign ifB.we3 = we3;  assign ifB.wa3 = wa3[2:0]; assign ifB.wd3 = wd3[7:0];
  assign ifB.we4 = we4;  assign ifB.wa4 = wa4[2:0]; assign ifB.wd4 = wd4[7:0];
  assign ifB.ra1 = ra1[2:0]; assign ifB.ra2 = ra2[2:0];
  assign ifB.rsv_en = rsv_en; assign ifB.rsv_a = rsv_a[2:0]; assign ifB.clr = clr;

  assign ifC.we3 = we3;  assign ifC.wa3 = wa3; assign ifC.wd3 = wd3;
  assign ifC.we4 = we4;  assign ifC.wa4 = wa4; assign ifC.wd4 = wd4;
  assign ifC.ra1 = ra1;  assign ifC.ra2 = ra2;
  assign ifC.rsv_en = rsv_en; assign ifC.rsv_a = rsv_a; assign ifC.clr = clr;

  banco_reg_sb #(.DataWidth(8),  .NumRegs(8),  .Bypass(1)) dutA (.clk(clk), .reset(reset), .bus(ifA));
  banco_reg_sb #(.DataWidth(8),  .NumRegs(8),  .Bypass(0)) dutB (.clk(clk), .reset(reset), .bus(ifB));
  banco_reg_sb #(.DataWidth(16), .NumRegs(32), .Bypass(1)) dutC (.clk(clk), .reset(reset), .bus(ifC));

  // ---------------- behavioural model ----------------
  // Channel 0 models both 8x8 instances (bypass only changes what is read),
  // channel 1 models the 16x32 instance.
  logic [15:0] m_reg  [2][32];
  logic        m_busy [2][32];

  function automatic int am(int ch, logic [4:0] a);
    return (ch == 0) ? int'(a[2:0]) : int'(a);
  endfunction

  function automatic logic [15:0] dm(int ch, logic [15:0] d);
    return (ch == 0) ? {8'h00, d[7:0]} : d;
  endfunction

  function automatic int nregs(int ch);
    return (ch == 0) ? 8 : 32;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int ch = 0; ch < 2; ch++)
        for (int r = 0; r < 32; r++) begin
          m_reg[ch][r]  <= '0;
          m_busy[ch][r] <= 1'b0;
        end
    end else begin
      for (int ch = 0; ch < 2; ch++) begin
        automatic int a3 = am(ch, wa3);
        automatic int a4 = am(ch, wa4);
        automatic int ar = am(ch, rsv_a);
        if (we4 && a4 != 0) m_reg[ch][a4] <= dm(ch, wd4);
        if (we3 && a3 != 0) m_reg[ch][a3] <= dm(ch, wd3);
        for (int r = 1; r < nregs(ch); r++) begin
          if (clr)                                      m_busy[ch][r] <= 1'b0;
          else if (rsv_en && ar == r)                   m_busy[ch][r] <= 1'b1;
          else if ((we3 && a3 == r) || (we4 && a4 == r)) m_busy[ch][r] <= 1'b0;
        end
      end
    end
  end

  function automatic logic [31:0] exp_rd(int ch, bit byp, logic [4:0] ra);
    automatic int a = am(ch, ra);
    if (!reset || a == 0)                     return 32'h0;
    if (byp && we3 && am(ch, wa3) == a)       return 32'(dm(ch, wd3));
    if (byp && we4 && am(ch, wa4) == a)       return 32'(dm(ch, wd4));
    return 32'(m_reg[ch][a]);
  endfunction

  function automatic logic [31:0] exp_busy(int ch, bit byp, logic [4:0] ra);
    automatic int a = am(ch, ra);
    if (!reset || a == 0)                               return 32'h0;
    if (byp && ((we3 && am(ch, wa3) == a) || (we4 && am(ch, wa4) == a))) return 32'h0;
    return {31'h0, m_busy[ch][a]};
  endfunction

  function automatic logic [31:0] exp_bvec(int ch);
    automatic logic [31:0] v = '0;
    for (int r = 1; r < nregs(ch); r++) v[r] = m_busy[ch][r];
    return v;
  endfunction

  task automatic cmp(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison of all three instances against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      cmp("A.rd1",   32'(ifA.rd1),      exp_rd(0, 1'b1, ra1));
      cmp("A.rd2",   32'(ifA.rd2),      exp_rd(0, 1'b1, ra2));
      cmp("A.busy1", 32'(ifA.busy1),    exp_busy(0, 1'b1, ra1));
      cmp("A.busy2", 32'(ifA.busy2),    exp_busy(0, 1'b1, ra2));
      cmp("A.bvec",  32'(ifA.busy_vec), exp_bvec(0));
      cmp("B.rd1",   32'(ifB.rd1),      exp_rd(0, 1'b0, ra1));
      cmp("B.rd2",   32'(ifB.rd2),      exp_rd(0, 1'b0, ra2));
      cmp("B.busy1", 32'(ifB.busy1),    exp_busy(0, 1'b0, ra1));
      cmp("B.busy2", 32'(ifB.busy2),    exp_busy(0, 1'b0, ra2));
      cmp("B.bvec",  32'(ifB.busy_vec), exp_bvec(0));
      cmp("C.rd1",   32'(ifC.rd1),      exp_rd(1, 1'b1, ra1));
      cmp("C.rd2",   32'(ifC.rd2),      exp_rd(1, 1'b1, ra2));
      cmp("C.busy1", 32'(ifC.busy1),    exp_busy(1, 1'b1, ra1));
      cmp("C.busy2", 32'(ifC.busy2),    exp_busy(1, 1'b1, ra2));
      cmp("C.bvec",  32'(ifC.busy_vec), exp_bvec(1));
    end
  end

  task automatic idle();
    we3 = 1'b0; we4 = 1'b0; rsv_en = 1'b0; clr = 1'b0;
  endtask

  // Advance to just after the next rising edge, where inputs are changed.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    idle();
    wa3 = '0; wa4 = '0; wd3 = '0; wd4 = '0; ra1 = '0; ra2 = '0; rsv_a = '0;
    reset = 1'b1;
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    chk_en = 1'b1;

    @(negedge clk);
    cmp("lit_rst_bvec", 32'(ifA.busy_vec), 32'h0);
    cmp("lit_rst_rd1",  32'(ifA.rd1),      32'h0);

    // Write 0xA5 to r3 and reserve r3 in the same cycle.
    tick(); we3 = 1; wa3 = 3; wd3 = 16'h00A5; rsv_en = 1; rsv_a = 3; ra1 = 3;
    @(negedge clk);
    cmp("lit_byp_r3_A", 32'(ifA.rd1), 32'hA5);
    tick(); idle();
    @(negedge clk);
    cmp("lit_r3_B",     32'(ifB.rd1),      32'hA5);
    cmp("lit_r3_bvec",  32'(ifA.busy_vec), 32'h08);
    // Asynchronous reset between edges.
    #1 reset = 1'b0;
    #1;
    cmp("lit_arst_rd1",  32'(ifA.rd1),      32'h0);
    cmp("lit_arst_bvec", 32'(ifA.busy_vec), 32'h0);
    cmp("lit_arst_C",    32'(ifC.rd1),      32'h0);
    tick(); tick(); reset = 1'b1;
    @(negedge clk);
    cmp("lit_post_rst_r3", 32'(ifB.rd1), 32'h0);

    // Register 0 is hardwired.
    tick(); we3 = 1; wa3 = 0; wd3 = 16'h00FF; rsv_en = 1; rsv_a = 0; ra1 = 0;
    @(negedge clk);
    cmp("lit_r0_wcyc", 32'(ifA.rd1), 32'h0);
    tick(); idle();
    @(negedge clk);
    cmp("lit_r0_rd1",  32'(ifA.rd1),      32'h0);
    cmp("lit_r0_bvec", 32'(ifA.busy_vec), 32'h0);

    // Write collision on r5, then independent writes to r2 / r6.
    tick(); we3 = 1; we4 = 1; wa3 = 5; wa4 = 5; wd3 = 16'h0011; wd4 = 16'h0022; ra1 = 5;
    @(negedge clk);
    cmp("lit_coll_byp", 32'(ifA.rd1), 32'h11);
    tick(); wa3 = 2; wd3 = 16'h0033; wa4 = 6; wd4 = 16'h0044;
    @(negedge clk);
    cmp("lit_coll_r5", 32'(ifB.rd1), 32'h11);
    tick(); idle(); ra1 = 2; ra2 = 6;
    @(negedge clk);
    cmp("lit_r2", 32'(ifB.rd1), 32'h33);
    cmp("lit_r6", 32'(ifB.rd2), 32'h44);

    // Bypass versus no bypass on r4.
    tick(); we3 = 1; wa3 = 4; wd3 = 16'h0010; ra2 = 4;
    tick(); idle(); we4 = 1; wa4 = 4; wd4 = 16'h007E;
    @(negedge clk);
    cmp("lit_byp_A_rd2",   32'(ifA.rd2), 32'h7E);
    cmp("lit_nobyp_B_rd2", 32'(ifB.rd2), 32'h10);
    tick(); idle();
    @(negedge clk);
    cmp("lit_after_B_rd2", 32'(ifB.rd2), 32'h7E);

    // Scoreboard sequence on r6.
    tick(); rsv_en = 1; rsv_a = 6; ra1 = 6;
    tick(); idle();
    @(negedge clk);
    cmp("lit_sb_bvec_A", 32'(ifA.busy_vec), 32'h40);
    cmp("lit_sb_busy1",  32'(ifA.busy1),    32'h1);
    cmp("lit_sb_bvec_C", 32'(ifC.busy_vec), 32'h40);
    tick(); we3 = 1; wa3 = 6; wd3 = 16'h0055;
    @(negedge clk);
    cmp("lit_sb_byp_busy1",   32'(ifA.busy1), 32'h0);
    cmp("lit_sb_nobyp_busy1", 32'(ifB.busy1), 32'h1);
    tick(); idle();
    @(negedge clk);
    cmp("lit_sb_wr_clr", 32'(ifA.busy_vec), 32'h0);
    tick(); rsv_en = 1; rsv_a = 6; we3 = 1; wa3 = 6; wd3 = 16'h0066;
    tick(); idle();
    @(negedge clk);
    cmp("lit_sb_rsv_wins", 32'(ifA.busy_vec), 32'h40);
    cmp("lit_sb_r6_data",  32'(ifB.rd1),      32'h66);
    tick(); clr = 1; rsv_en = 1; rsv_a = 6;
    tick(); idle();
    @(negedge clk);
    cmp("lit_sb_clr", 32'(ifA.busy_vec), 32'h0);

    // Wide instance: r31 and a reservation of the top region.
    tick(); we3 = 1; wa3 = 31; wd3 = 16'hBEEF; rsv_en = 1; rsv_a = 30;
    tick(); idle(); ra1 = 31; ra2 = 31;
    @(negedge clk);
    cmp("lit_C_rd1",  32'(ifC.rd1),      32'hBEEF);
    cmp("lit_C_rd2",  32'(ifC.rd2),      32'hBEEF);
    cmp("lit_A_rd1",  32'(ifA.rd1),      32'hEF);
    cmp("lit_C_bvec", 32'(ifC.busy_vec), 32'h4000_0000);
    cmp("lit_A_bvec", 32'(ifA.busy_vec), 32'h40);

    // Mixed traffic on both ports, checked by the model every cycle.
    for (int i = 1; i < 32; i++) begin
      tick();
      we3 = 1; wa3 = 5'(i); wd3 = 16'(i * 257 + 1);
      we4 = 1; wa4 = 5'(31 - i); wd4 = 16'(i * 3);
      ra1 = 5'(i - 1); ra2 = 5'(31 - i);
      rsv_en = (i % 3 == 0); rsv_a = 5'(i + 1);
      clr = (i % 10 == 0);
    end
    tick(); idle();
    for (int i = 0; i < 32; i++) begin
      ra1 = 5'(i); ra2 = 5'(31 - i);
      tick();
    end

    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
